// File: rtl/alu_md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states
// and the iteration-counter width helper.
package alu_md_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned bpc);
    return $clog2(width / bpc + 1);
  endfunction

endpackage

// File: rtl/alu_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface alu_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/md_step.sv
// One radix-2 step: shift-add for multiply, restoring trial-subtract for divide.
// {hi_i, lo_i} is the running accumulator; opnd_i is the multiplicand or divisor.
module md_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    rem  = {hi_i, lo_i[WIDTH-1]};
    diff = rem - {1'b0, opnd_i};
    if (div_i) begin
      // diff[WIDTH] set means the trial subtraction underflowed: restore.
      hi_o = diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, retiring BPC bits per cycle
// on unsigned magnitudes and fixing signs up in the single FIN cycle.
module alu_muldiv_unit
  import alu_md_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input logic               clk,
  input logic               rst_n,
  alu_muldiv_unit_if.slave  bus
);

  localparam int unsigned N  = WIDTH / BPC;
  localparam int unsigned CW = cnt_width(WIDTH, BPC);

  state_e           state_q, state_d;
  logic             is_div_q, psign_q, rsign_q, dbz_q;
  logic [WIDTH-1:0] opnd_q, acc_hi_q, acc_lo_q, hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q, dbz_out_q;

  logic             start_ok, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo;
  logic [WIDTH-1:0] quot, rem, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign start_ok = (state_q == IDLE) && bus.start && !bus.cancel;
  // op[0] clear selects the signed variants.
  assign a_neg    = ~bus.op[0] & bus.a[WIDTH-1];
  assign b_neg    = ~bus.op[0] & bus.b[WIDTH-1];
  assign a_mag    = a_neg ? -bus.a : bus.a;
  assign b_mag    = b_neg ? -bus.b : bus.b;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    logic [WIDTH-1:0] hi_in, lo_in, hi_out, lo_out;
    if (i == 0) begin : g_first
      assign hi_in = acc_hi_q;
      assign lo_in = acc_lo_q;
    end else begin : g_next
      assign hi_in = g_step[i-1].hi_out;
      assign lo_in = g_step[i-1].lo_out;
    end
    md_step #(
      .WIDTH(WIDTH)
    ) u_md_step (
      .div_i (is_div_q),
      .opnd_i(opnd_q),
      .hi_i  (hi_in),
      .lo_i  (lo_in),
      .hi_o  (hi_out),
      .lo_o  (lo_out)
    );
  end
  assign step_hi = g_step[BPC-1].hi_out;
  assign step_lo = g_step[BPC-1].lo_out;

  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = psign_q ? -prod : prod;
    quot     = dbz_q ? '1 : (psign_q ? -acc_lo_q : acc_lo_q);
    rem      = rsign_q ? -acc_hi_q : acc_hi_q;
    if (is_div_q) begin
      res_hi = rem;
      res_lo = quot;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (bus.cancel) state_d = IDLE;
               else if (cnt_q == CW'(1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      psign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      dbz_q     <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
      if (start_ok) begin
        is_div_q <= bus.op[1];
        psign_q  <= a_neg ^ b_neg;
        rsign_q  <= a_neg;
        dbz_q    <= (bus.b == '0);
        // Multiply shifts the multiplier out of lo; divide shifts the dividend out of lo.
        opnd_q   <= bus.op[1] ? b_mag : a_mag;
        acc_lo_q <= bus.op[1] ? a_mag : b_mag;
        acc_hi_q <= '0;
        cnt_q    <= CW'(N);
      end
      if (state_q == RUN) begin
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
        cnt_q    <= cnt_q - CW'(1);
      end
      if (state_q == FIN && !bus.cancel) begin
        hi_q      <= res_hi;
        lo_q      <= res_lo;
        done_q    <= 1'b1;
        dbz_out_q <= is_div_q & dbz_q;
      end
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_out_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed-vector bench for alu_muldiv_unit: a BPC=1 instance for the vector table and
// multi-cycle sequences, plus a BPC=4 instance for the shortened-latency case.
module tb_alu_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_muldiv_unit_if #(.WIDTH(32)) bus ();
  alu_muldiv_unit_if #(.WIDTH(32)) bus4 ();

  alu_muldiv_unit #(.WIDTH(32), .BPC(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  alu_muldiv_unit #(.WIDTH(32), .BPC(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Results captured by run_op.
  int          r_busy, r_done_at, r_dones;
  logic [31:0] r_hi, r_lo;
  logic        r_dbz;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Cycle k is the k-th cycle after the start edge; sampled 1 time unit after each edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    r_busy = 0; r_done_at = 0; r_dones = 0;
    r_hi = 'x; r_lo = 'x; r_dbz = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      if (bus.busy) r_busy++;
      if (bus.done) begin
        r_dones++;
        if (r_done_at == 0) begin
          r_done_at = k;
          r_hi      = bus.hi;
          r_lo      = bus.lo;
          r_dbz     = bus.div_by_zero;
        end
      end
      if (r_done_at != 0 && k > r_done_at) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles_count_done(input int n, output int dones);
    dones = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
  endtask

  vec_t vecs[9];
  int   dones;

  initial begin
    vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5] = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
    vecs[7] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

    rst_n = 1'b0;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.cancel = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
    bus4.start = 0; bus4.op = 0; bus4.a = 0; bus4.b = 0; bus4.cancel = 0;
    bus4.hi_we = 0; bus4.lo_we = 0; bus4.wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset dbz", 64'(bus.div_by_zero), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d hi", i), 64'(r_hi), 64'(vecs[i].hi));
      check($sformatf("v%0d lo", i), 64'(r_lo), 64'(vecs[i].lo));
      check($sformatf("v%0d div_by_zero", i), 64'(r_dbz), 64'(vecs[i].dbz));
      check($sformatf("v%0d done cycle", i), 64'(r_done_at), 64'd34);
      check($sformatf("v%0d busy cycles", i), 64'(r_busy), 64'd33);
      check($sformatf("v%0d done pulses", i), 64'(r_dones), 64'd1);
    end

    // Cancel mid-divide: HI/LO keep the MTHI/MTLO values and no done appears.
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h5678;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel busy", 64'(bus.busy), 64'd0);
    check("cancel done", 64'(bus.done), 64'd0);
    check("cancel hi", 64'(bus.hi), 64'h1234);
    check("cancel lo", 64'(bus.lo), 64'h5678);
    run_op(2'b01, 32'd6, 32'd7);
    check("post-cancel lo", 64'(r_lo), 64'd42);
    check("post-cancel hi", 64'(r_hi), 64'd0);
    check("post-cancel done cycle", 64'(r_done_at), 64'd34);
    idle_cycles_count_done(40, dones);
    check("post-cancel stray done", 64'(dones), 64'd0);

    // Start and MTHI while busy are ignored.
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0; r_lo = 'x; r_hi = 'x;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd9;
        bus.hi_we = 1'b1; bus.wdata = 32'hAAAA;
      end else begin
        bus.start = 1'b0; bus.hi_we = 1'b0;
      end
      if (bus.done) begin
        dones++;
        r_lo = bus.lo;
        r_hi = bus.hi;
      end
      @(posedge clk); #1;
    end
    check("busy-window done pulses", 64'(dones), 64'd1);
    check("busy-window lo", 64'(r_lo), 64'd6);
    check("busy-window hi", 64'(r_hi), 64'd0);
    check("busy-window final hi", 64'(bus.hi), 64'd0);

    // Reset mid-run clears everything and suppresses done.
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid-reset busy", 64'(bus.busy), 64'd0);
    check("mid-reset hi", 64'(bus.hi), 64'd0);
    check("mid-reset lo", 64'(bus.lo), 64'd0);
    idle_cycles_count_done(40, dones);
    check("mid-reset stray done", 64'(dones), 64'd0);

    // BPC = 4: same signed product, done 10 cycles after the start cycle.
    bus4.start = 1'b1; bus4.op = 2'b00; bus4.a = 32'hFFFFFFF9; bus4.b = 32'd3;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    r_busy = 0; r_done_at = 0;
    for (int k = 1; k <= 30; k++) begin
      if (bus4.busy) r_busy++;
      if (bus4.done && r_done_at == 0) begin
        r_done_at = k;
        r_hi = bus4.hi;
        r_lo = bus4.lo;
      end
      @(posedge clk); #1;
    end
    check("bpc4 done cycle", 64'(r_done_at), 64'd10);
    check("bpc4 busy cycles", 64'(r_busy), 64'd9);
    check("bpc4 hi", 64'(r_hi), 64'hFFFFFFFF);
    check("bpc4 lo", 64'(r_lo), 64'hFFFFFFEB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
